// File: rtl/dispatch_sb.sv
// In-order dispatch stage: operand resolution (regfile or forwarding), per-register
// long-latency scoreboard, structural limits, and a registered valid/ready hand-off to EXE.

module dispatch_sb_opsel #(
  parameter int FWD_SRC = 4,
  parameter int DATA_W  = 32
) (
  input  logic [4:0]                    addr_i,
  input  logic [DATA_W-1:0]             rf_data_i,
  input  logic [FWD_SRC-1:0]            fwd_valid_i,
  input  logic [FWD_SRC-1:0][4:0]       fwd_addr_i,
  input  logic [FWD_SRC-1:0][DATA_W-1:0] fwd_data_i,
  output logic [DATA_W-1:0]             data_o
);
  // Walk oldest to youngest so the lowest-index (youngest) match wins.
  always_comb begin
    data_o = rf_data_i;
    for (int f = FWD_SRC - 1; f >= 0; f--)
      if (fwd_valid_i[f] && fwd_addr_i[f] == addr_i) data_o = fwd_data_i[f];
    if (addr_i == 5'd0) data_o = '0;
  end
endmodule

module dispatch_sb #(
  parameter int ISSUE_WIDTH   = 2,
  parameter int FWD_SRC       = 4,
  parameter int WB_PORTS      = 2,
  parameter int MEM_PER_CYCLE = 1,
  parameter int CSR_PER_CYCLE = 1,
  parameter int DATA_W        = 32,
  parameter int PAYLOAD_W     = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic [ISSUE_WIDTH-1:0]                   id_valid_i,
  input  logic [ISSUE_WIDTH-1:0][1:0]              id_rs_valid_i,
  input  logic [ISSUE_WIDTH-1:0][1:0][4:0]         id_rs_addr_i,
  input  logic [ISSUE_WIDTH-1:0]                   id_rd_valid_i,
  input  logic [ISSUE_WIDTH-1:0][4:0]              id_rd_addr_i,
  input  logic [ISSUE_WIDTH-1:0]                   id_is_mem_i,
  input  logic [ISSUE_WIDTH-1:0]                   id_is_csr_i,
  input  logic [ISSUE_WIDTH-1:0]                   id_long_lat_i,
  input  logic [ISSUE_WIDTH-1:0]                   id_use_imm_i,
  input  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]       id_imm_i,
  input  logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]    id_payload_i,
  output logic [ISSUE_WIDTH-1:0]                   ib_accept_o,
  output logic                                     stallreq_o,
  output logic [ISSUE_WIDTH-1:0][1:0][4:0]         rf_raddr_o,
  input  logic [ISSUE_WIDTH-1:0][1:0][DATA_W-1:0]  rf_rdata_i,
  input  logic [FWD_SRC-1:0]                       fwd_valid_i,
  input  logic [FWD_SRC-1:0][4:0]                  fwd_addr_i,
  input  logic [FWD_SRC-1:0][DATA_W-1:0]           fwd_data_i,
  input  logic [WB_PORTS-1:0]                      wb_valid_i,
  input  logic [WB_PORTS-1:0][4:0]                 wb_addr_i,
  input  logic                                     exe_ready_i,
  output logic [ISSUE_WIDTH-1:0]                   exe_valid_o,
  output logic [ISSUE_WIDTH-1:0][DATA_W-1:0]       exe_oprand1_o,
  output logic [ISSUE_WIDTH-1:0][DATA_W-1:0]       exe_oprand2_o,
  output logic [ISSUE_WIDTH-1:0]                   exe_rd_valid_o,
  output logic [ISSUE_WIDTH-1:0][4:0]              exe_rd_addr_o,
  output logic [ISSUE_WIDTH-1:0][DATA_W-1:0]       exe_imm_o,
  output logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]    exe_payload_o
);

  logic [31:0]                            busy_q, busy_d;
  logic [ISSUE_WIDTH-1:0]                 exe_valid_q;
  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]     op1_q, op2_q, imm_q;
  logic [ISSUE_WIDTH-1:0]                 rd_valid_q;
  logic [ISSUE_WIDTH-1:0][4:0]            rd_addr_q;
  logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]  payload_q;

  logic [ISSUE_WIDTH-1:0][1:0][DATA_W-1:0] opnd;
  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]      op2_d;
  logic [ISSUE_WIDTH-1:0]                  ok, issue, accept;
  logic                                    advance, run;
  int                                      mem_cnt, csr_cnt;

  assign rf_raddr_o = id_rs_addr_i;
  assign advance    = exe_ready_i | ~|exe_valid_q;
  assign accept     = (advance & ~flush) ? issue : '0;
  assign ib_accept_o = accept;
  assign stallreq_o = advance & |(id_valid_i & ~issue);

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
    for (genvar k = 0; k < 2; k++) begin : g_src
      dispatch_sb_opsel #(.FWD_SRC(FWD_SRC), .DATA_W(DATA_W)) u_opsel (
        .addr_i      (id_rs_addr_i[g][k]),
        .rf_data_i   (rf_rdata_i[g][k]),
        .fwd_valid_i (fwd_valid_i),
        .fwd_addr_i  (fwd_addr_i),
        .fwd_data_i  (fwd_data_i),
        .data_o      (opnd[g][k])
      );
    end
    assign op2_d[g] = id_use_imm_i[g] ? id_imm_i[g] : opnd[g][1];
  end

  // Hazard check; the running AND keeps the issue mask prefix-closed.
  always_comb begin
    ok      = '0;
    issue   = '0;
    run     = 1'b1;
    mem_cnt = 0;
    csr_cnt = 0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      ok[i] = id_valid_i[i];
      if (id_valid_i[i] && id_is_mem_i[i]) mem_cnt = mem_cnt + 1;
      if (id_valid_i[i] && id_is_csr_i[i]) csr_cnt = csr_cnt + 1;
      if (mem_cnt > MEM_PER_CYCLE || csr_cnt > CSR_PER_CYCLE) ok[i] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (id_rs_valid_i[i][k]) begin
          if (busy_q[id_rs_addr_i[i][k]]) ok[i] = 1'b0;
          for (int j = 0; j < ISSUE_WIDTH; j++)
            if (j < i && id_valid_i[j] && id_rd_valid_i[j] && id_rd_addr_i[j] != 5'd0 &&
                id_rd_addr_i[j] == id_rs_addr_i[i][k]) ok[i] = 1'b0;
        end
      end
      if (id_rd_valid_i[i] && busy_q[id_rd_addr_i[i]]) ok[i] = 1'b0;
      run      = run & ok[i];
      issue[i] = run;
    end
  end

  // Scoreboard next state: clear first so a same-cycle set wins; flush wipes all.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < WB_PORTS; w++)
      if (wb_valid_i[w]) busy_d[wb_addr_i[w]] = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++)
      if (accept[i] && id_long_lat_i[i] && id_rd_valid_i[i] && id_rd_addr_i[i] != 5'd0)
        busy_d[id_rd_addr_i[i]] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      exe_valid_q <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      rd_valid_q  <= '0;
      rd_addr_q   <= '0;
      payload_q   <= '0;
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        exe_valid_q <= '0;
      end else if (advance) begin
        exe_valid_q <= issue;
        rd_valid_q  <= id_rd_valid_i;
        rd_addr_q   <= id_rd_addr_i;
        imm_q       <= id_imm_i;
        payload_q   <= id_payload_i;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          op1_q[i] <= opnd[i][0];
          op2_q[i] <= op2_d[i];
        end
      end
    end
  end

  assign exe_valid_o    = exe_valid_q;
  assign exe_oprand1_o  = op1_q;
  assign exe_oprand2_o  = op2_q;
  assign exe_rd_valid_o = rd_valid_q;
  assign exe_rd_addr_o  = rd_addr_q;
  assign exe_imm_o      = imm_q;
  assign exe_payload_o  = payload_q;

endmodule

// File: tb/tb_dispatch_sb.sv
// Directed bench for dispatch_sb: forwarding, intra-group RAW, scoreboard, limits,
// backpressure, flush and async reset. A second instance runs with two memory ops per cycle.
module tb_dispatch_sb;
  localparam int IW = 2;
  localparam int FS = 4;
  localparam int WB = 2;
  localparam int DW = 32;
  localparam int PW = 64;

  logic clk, rst, flush;
  logic [IW-1:0]               id_valid, id_rd_valid, id_is_mem, id_is_csr, id_long_lat, id_use_imm;
  logic [IW-1:0][1:0]          id_rs_valid;
  logic [IW-1:0][1:0][4:0]     id_rs_addr;
  logic [IW-1:0][4:0]          id_rd_addr;
  logic [IW-1:0][DW-1:0]       id_imm;
  logic [IW-1:0][PW-1:0]       id_payload;
  logic [IW-1:0]               ib_accept, ib_accept2;
  logic                        stallreq, stallreq2;
  logic [IW-1:0][1:0][4:0]     rf_raddr, rf_raddr2;
  logic [IW-1:0][1:0][DW-1:0]  rf_rdata, rf_rdata2;
  logic [FS-1:0]               fwd_valid;
  logic [FS-1:0][4:0]          fwd_addr;
  logic [FS-1:0][DW-1:0]       fwd_data;
  logic [WB-1:0]               wb_valid;
  logic [WB-1:0][4:0]          wb_addr;
  logic                        exe_ready;
  logic [IW-1:0]               exe_valid, exe_rd_valid, exe_valid2, exe_rd_valid2;
  logic [IW-1:0][DW-1:0]       op1, op2, exe_imm, op1_2, op2_2, exe_imm2;
  logic [IW-1:0][4:0]          exe_rd_addr, exe_rd_addr2;
  logic [IW-1:0][PW-1:0]       exe_payload, exe_payload2;

  int total = 0;
  int bad   = 0;

  dispatch_sb #(.ISSUE_WIDTH(IW), .FWD_SRC(FS), .WB_PORTS(WB), .MEM_PER_CYCLE(1),
                .CSR_PER_CYCLE(1), .DATA_W(DW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid_i(id_valid), .id_rs_valid_i(id_rs_valid), .id_rs_addr_i(id_rs_addr),
    .id_rd_valid_i(id_rd_valid), .id_rd_addr_i(id_rd_addr), .id_is_mem_i(id_is_mem),
    .id_is_csr_i(id_is_csr), .id_long_lat_i(id_long_lat), .id_use_imm_i(id_use_imm),
    .id_imm_i(id_imm), .id_payload_i(id_payload), .ib_accept_o(ib_accept),
    .stallreq_o(stallreq), .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .fwd_valid_i(fwd_valid), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .exe_ready_i(exe_ready),
    .exe_valid_o(exe_valid), .exe_oprand1_o(op1), .exe_oprand2_o(op2),
    .exe_rd_valid_o(exe_rd_valid), .exe_rd_addr_o(exe_rd_addr), .exe_imm_o(exe_imm),
    .exe_payload_o(exe_payload));

  dispatch_sb #(.ISSUE_WIDTH(IW), .FWD_SRC(FS), .WB_PORTS(WB), .MEM_PER_CYCLE(2),
                .CSR_PER_CYCLE(1), .DATA_W(DW), .PAYLOAD_W(PW)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid_i(id_valid), .id_rs_valid_i(id_rs_valid), .id_rs_addr_i(id_rs_addr),
    .id_rd_valid_i(id_rd_valid), .id_rd_addr_i(id_rd_addr), .id_is_mem_i(id_is_mem),
    .id_is_csr_i(id_is_csr), .id_long_lat_i(id_long_lat), .id_use_imm_i(id_use_imm),
    .id_imm_i(id_imm), .id_payload_i(id_payload), .ib_accept_o(ib_accept2),
    .stallreq_o(stallreq2), .rf_raddr_o(rf_raddr2), .rf_rdata_i(rf_rdata2),
    .fwd_valid_i(fwd_valid), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .exe_ready_i(exe_ready),
    .exe_valid_o(exe_valid2), .exe_oprand1_o(op1_2), .exe_oprand2_o(op2_2),
    .exe_rd_valid_o(exe_rd_valid2), .exe_rd_addr_o(exe_rd_addr2), .exe_imm_o(exe_imm2),
    .exe_payload_o(exe_payload2));

  // Register file model: register n reads as 0x10000 + n.
  always_comb begin
    for (int s = 0; s < IW; s++)
      for (int k = 0; k < 2; k++) begin
        rf_rdata[s][k]  = 32'h0001_0000 + {27'd0, rf_raddr[s][k]};
        rf_rdata2[s][k] = 32'h0001_0000 + {27'd0, rf_raddr2[s][k]};
      end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    flush = 0; id_valid = '0; id_rs_valid = '0; id_rs_addr = '0; id_rd_valid = '0;
    id_rd_addr = '0; id_is_mem = '0; id_is_csr = '0; id_long_lat = '0; id_use_imm = '0;
    id_imm = '0; id_payload = '0; fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    wb_valid = '0; wb_addr = '0;
  endtask

  task automatic slot(input int s, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input logic mem, input logic ll);
    id_valid[s]    = 1'b1;
    id_rs_valid[s] = 2'b11;
    id_rs_addr[s][0] = r1;
    id_rs_addr[s][1] = r2;
    id_rd_valid[s] = 1'b1;
    id_rd_addr[s]  = rd;
    id_is_mem[s]   = mem;
    id_long_lat[s] = ll;
    id_use_imm[s]  = 1'b0;
    id_imm[s]      = '0;
    id_payload[s]  = 64'hA5A5_0000_0000_0000 | {59'd0, rd};
  endtask

  task automatic noslot(input int s);
    id_valid[s] = 1'b0; id_rs_valid[s] = '0; id_rd_valid[s] = 1'b0;
    id_is_mem[s] = 1'b0; id_long_lat[s] = 1'b0;
  endtask

  initial begin
    rst = 1; exe_ready = 1; clr_in();
    #1;
    chk("rst_valid", exe_valid, 2'b00);
    chk("rst_op1", op1, '0);
    chk("rst_payload", exe_payload, '0);
    tick();
    rst = 0;

    // Intra-group RAW: slot1 reads r3 written by slot0.
    slot(0, 5'd3, 5'd1, 5'd2, 0, 0);
    slot(1, 5'd5, 5'd3, 5'd4, 0, 0);
    #1;
    chk("raw_accept", ib_accept, 2'b01);
    chk("raw_stall", stallreq, 1'b1);
    tick();
    chk("raw_valid", exe_valid, 2'b01);
    chk("raw_op1", op1[0], 32'h0001_0001);
    chk("raw_op2", op2[0], 32'h0001_0002);
    chk("raw_rd", exe_rd_addr[0], 5'd3);
    chk("raw_payload", exe_payload[0], 64'hA5A5_0000_0000_0003);
    slot(0, 5'd5, 5'd3, 5'd4, 0, 0);
    noslot(1);
    fwd_valid[0] = 1'b1; fwd_addr[0] = 5'd3; fwd_data[0] = 32'h3333;
    #1;
    chk("raw2_accept", ib_accept, 2'b01);
    chk("raw2_stall", stallreq, 1'b0);
    tick();
    chk("raw2_op1_fwd", op1[0], 32'h3333);
    chk("raw2_op2", op2[0], 32'h0001_0004);

    // Forwarding priority and r0.
    clr_in();
    fwd_valid = 4'b0111;
    fwd_addr[0] = 5'd7; fwd_data[0] = 32'hAAAA;
    fwd_addr[1] = 5'd0; fwd_data[1] = 32'hCCCC;
    fwd_addr[2] = 5'd7; fwd_data[2] = 32'hBBBB;
    slot(0, 5'd10, 5'd7, 5'd0, 0, 0);
    slot(1, 5'd11, 5'd0, 5'd7, 0, 0);
    id_use_imm[1] = 1'b1; id_imm[1] = 32'h55;
    #1;
    chk("fwd_accept", ib_accept, 2'b11);
    tick();
    chk("fwd_op1_pri", op1[0], 32'hAAAA);
    chk("fwd_op2_r0", op2[0], 32'h0);
    chk("fwd_s1_op1_r0", op1[1], 32'h0);
    chk("fwd_s1_imm", op2[1], 32'h55);
    chk("fwd_s1_immout", exe_imm[1], 32'h55);

    // Scoreboard: load r8 then dependent add stalls until the cycle after wb.
    clr_in();
    slot(0, 5'd8, 5'd1, 5'd0, 1, 1);
    #1;
    chk("ld_accept", ib_accept, 2'b01);
    tick();
    slot(0, 5'd9, 5'd8, 5'd1, 0, 0);
    noslot(1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("sb_hold_accept", ib_accept, 2'b00);
      chk("sb_hold_stall", stallreq, 1'b1);
      tick();
    end
    wb_valid[0] = 1'b1; wb_addr[0] = 5'd8;
    #1;
    chk("sb_wb_cycle", ib_accept, 2'b00);
    tick();
    wb_valid = '0;
    #1;
    chk("sb_after_wb", ib_accept, 2'b01);
    tick();
    chk("sb_issue_valid", exe_valid, 2'b01);
    chk("sb_issue_op1", op1[0], 32'h0001_0008);

    // Memory limit: 1/cycle on dut, 2/cycle on dut2.
    clr_in();
    slot(0, 5'd12, 5'd1, 5'd2, 1, 0);
    slot(1, 5'd13, 5'd1, 5'd2, 1, 0);
    #1;
    chk("mem1_accept", ib_accept, 2'b01);
    chk("mem1_stall", stallreq, 1'b1);
    chk("mem2_accept", ib_accept2, 2'b11);
    tick();
    slot(0, 5'd13, 5'd1, 5'd2, 1, 0);
    slot(1, 5'd14, 5'd1, 5'd2, 1, 0);
    #1;
    chk("mem1_accept_b", ib_accept, 2'b01);
    tick();

    // Backpressure: outputs hold for two cycles.
    clr_in();
    slot(0, 5'd20, 5'd1, 5'd2, 0, 0);
    slot(1, 5'd21, 5'd3, 5'd4, 0, 0);
    #1;
    chk("bp_accept", ib_accept, 2'b11);
    tick();
    exe_ready = 0;
    slot(0, 5'd22, 5'd5, 5'd6, 0, 0);
    slot(1, 5'd23, 5'd7, 5'd8, 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_hold_accept", ib_accept, 2'b00);
      chk("bp_hold_stall", stallreq, 1'b0);
      tick();
      chk("bp_hold_valid", exe_valid, 2'b11);
      chk("bp_hold_op1", op1[0], 32'h0001_0001);
      chk("bp_hold_op2", op2[1], 32'h0001_0004);
      chk("bp_hold_rd", exe_rd_addr[1], 5'd21);
    end
    exe_ready = 1;
    #1;
    chk("bp_release_accept", ib_accept, 2'b11);
    tick();
    chk("bp_new_op1", op1[0], 32'h0001_0005);
    chk("bp_new_rd", exe_rd_addr[1], 5'd23);

    // Flush clears busy bits and the output valid.
    clr_in();
    slot(0, 5'd8, 5'd1, 5'd0, 1, 1);
    #1;
    tick();
    slot(0, 5'd9, 5'd8, 5'd1, 0, 0);
    noslot(1);
    #1;
    chk("fl_pre_accept", ib_accept, 2'b00);
    flush = 1;
    #1;
    chk("fl_accept", ib_accept, 2'b00);
    tick();
    flush = 0;
    #1;
    chk("fl_valid", exe_valid, 2'b00);
    chk("fl_busy_clear", ib_accept, 2'b01);
    tick();
    chk("fl_issue_valid", exe_valid, 2'b01);

    // Async reset in the middle of a stall.
    clr_in();
    slot(0, 5'd8, 5'd1, 5'd0, 1, 1);
    #1;
    tick();
    chk("ar_pre_valid", exe_valid, 2'b01);
    chk("ar_pre_rd", exe_rd_addr[0], 5'd8);
    slot(0, 5'd9, 5'd8, 5'd1, 0, 0);
    noslot(1);
    #1;
    chk("ar_pre_stall", stallreq, 1'b1);
    rst = 1;
    #1;
    chk("ar_valid", exe_valid, 2'b00);
    chk("ar_rd", exe_rd_addr, '0);
    chk("ar_payload", exe_payload, '0);
    rst = 0;
    #1;
    chk("ar_busy_clear", ib_accept, 2'b01);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dispatch_sb.md
Name: dispatch_sb

Overview:
- Parametrised in-order dispatch stage, sitting between the decoder/instruction buffer and the EXE stage.
- Issues up to ISSUE_WIDTH instructions per cycle, each with fully resolved operands.
- Operands come from the register file or a priority-ordered set of FWD_SRC forwarding sources.
- A per-register scoreboard stalls on long-latency (load, mul/div) results, which cannot be forwarded at dispatch.
- Per-cycle structural limits (memory ops, CSR ops) and a valid/ready handshake to EXE replace the fixed two-slot pairing rules.

Parameters:
ISSUE_WIDTH, 2, instruction slots per cycle (1..4)
FWD_SRC, 4, forwarding sources; index 0 is youngest and has highest priority
WB_PORTS, 2, scoreboard-clear (writeback) ports
MEM_PER_CYCLE, 1, max memory instructions issued per cycle
CSR_PER_CYCLE, 1, max CSR instructions issued per cycle
DATA_W, 32, operand width
PAYLOAD_W, 64, opaque per-slot payload (aluop, alusel, pc, excp...), passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  pipeline flush
id_valid_i  in  ISSUE_WIDTH  slot valid
id_rs_valid_i  in  ISSUE_WIDTH*2  source read enables {rs2,rs1}
id_rs_addr_i  in  ISSUE_WIDTH*2*5  source addresses
id_rd_valid_i  in  ISSUE_WIDTH  destination write enable
id_rd_addr_i  in  ISSUE_WIDTH*5  destination address
id_is_mem_i / id_is_csr_i / id_long_lat_i  in  ISSUE_WIDTH each  class flags
id_use_imm_i  in  ISSUE_WIDTH  oprand2 takes the immediate
id_imm_i  in  ISSUE_WIDTH*DATA_W  immediate
id_payload_i  in  ISSUE_WIDTH*PAYLOAD_W  pass-through payload
ib_accept_o  out  ISSUE_WIDTH  slots consumed this cycle
stallreq_o  out  1  a valid slot was blocked by a hazard
rf_raddr_o  out  ISSUE_WIDTH*2*5  register file read addresses (combinational)
rf_rdata_i  in  ISSUE_WIDTH*2*DATA_W  register file read data
fwd_valid_i / fwd_addr_i / fwd_data_i  in  FWD_SRC / FWD_SRC*5 / FWD_SRC*DATA_W  forwarding sources
wb_valid_i / wb_addr_i  in  WB_PORTS / WB_PORTS*5  long-latency completion
exe_ready_i  in  1  EXE can accept
exe_valid_o  out  ISSUE_WIDTH  registered slot valid
exe_oprand1_o / exe_oprand2_o  out  ISSUE_WIDTH*DATA_W each  resolved operands
exe_rd_valid_o / exe_rd_addr_o / exe_imm_o / exe_payload_o  out  registered pass-through

Behaviour:
- Reset: every exe_* output is 0 and every scoreboard busy bit is 0.
- Operand select, per slot and source:
  - address 0 → 0;
  - otherwise the lowest-index fwd source with matching valid addr;
  - otherwise rf_rdata.
  - oprand2 = imm when use_imm.
- Slot i is blocked if any of the following holds:
  - it is not valid;
  - it reads a register that an earlier valid slot in the same group writes (rd != 0);
  - it reads a busy register;
  - it writes a busy register (WAW);
  - issuing it would exceed MEM_PER_CYCLE or CSR_PER_CYCLE, counted over slots 0..i.
- Issue mask is prefix-closed: slot i issues only if slots 0..i-1 issue, which keeps issue in order.
- advance = exe_ready_i | ~|exe_valid_o.
  - ib_accept_o = advance & ~flush ? issue mask : 0.
  - When advance, output registers load the issued slots; non-issued slots load valid=0.
  - When ~advance, output registers hold.
- stallreq_o = some valid slot is not issued due to a hazard or a limit while advance is high. Combinational.
- Scoreboard:
  - Set: on issue of a slot with long_lat & rd_valid & rd != 0, set busy[rd] at the next edge.
  - Clear: wb_valid_i clears busy[wb_addr] at the next edge. A busy bit does not clear within the same cycle, so a consumer may dispatch the cycle after the wb.
  - Set and clear of the same register in the same cycle → set wins.
  - Clear of an already-idle register is ignored.
- Flush (highest priority over all but reset):
  - exe_valid_o ← 0 and all busy bits ← 0 at the next edge.
  - ib_accept_o = 0 in the flush cycle.
- Reset asserted mid-operation clears outputs and scoreboard immediately; stale wb after reset is harmless.
- Latency: 1 cycle from accept to exe_valid_o.

Test Plan:
- ISSUE_WIDTH=2; slot0 add r3←r1,r2; slot1 sub r5←r3,r4, both valid, exe_ready=1 → ib_accept=01, stallreq=1; next cycle slot1 issues alone with r3 taken from fwd src 0.
- fwd0 and fwd2 both target r7 (0xAAAA / 0xBBBB); slot0 reads r7 → exe_oprand1 = 0xAAAA; slot reading r0 with fwd on r0 → 0.
- ld r8 issued (long_lat) → busy[8]; add r9←r8 held 3 cycles with stallreq=1; wb r8 in cycle N → add issues in cycle N+1.
- Two loads in one group, MEM_PER_CYCLE=1 → accept=01, then 01; with MEM_PER_CYCLE=2 → accept=11.
- exe_ready=0 for 2 cycles with exe_valid=11 → outputs hold bit-exact, accept=00; ready=1 → new group loads.
- busy[8] set, flush → exe_valid=0, busy cleared, next add r9←r8 issues immediately; async rst mid-stall → all outputs 0 without a clock edge.
